// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV64 main controller.
package mc_ctrl_pkg;

  // Controller states; one instruction walks a subset of these.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_ALU_WB   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_TRAP     = 4'd11
  } state_e;

  // Major opcodes recognised by the decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operand-B select.
  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // ALU operation class handed to the ALU control unit.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Trap causes.
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Moore part of the control word; fetch_ld is later qualified by mem_ready
  // to form ir_write and pc_write.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       fetch_ld;
    logic       pc_write_cond;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       trap;
  } ctrl_out_t;

  // States that wait on the memory handshake and run the timeout counter.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath/memory signal bundle.
interface mc_control_fsm_if #(
  parameter int RET_W = 32
);
  logic             run;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             pc_write_cond;
  logic             pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [RET_W-1:0] retired;

  modport master (
    input  run, opcode, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           trap, trap_cause, retired
  );

  modport slave (
    output run, opcode, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           trap, trap_cause, retired
  );
endinterface

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// Saturating wait counter for memory handshakes; flags when the limit is hit.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_limit;

  assign w_at_limit = (r_count == CNT_W'(MEM_TIMEOUT));
  assign o_timeout  = w_at_limit;

  // Count idle handshake cycles, clearing on state entry and holding at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_limit) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end
endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input logic               clk,
  input logic               rst_n,
  mc_control_fsm_if.master  bus
);
  state_e           r_state;
  state_e           w_state_nxt;
  ctrl_out_t        r_out;
  logic [1:0]       r_trap_cause;
  logic [1:0]       w_cause_nxt;
  logic [RET_W-1:0] r_retired;
  logic             w_in_wait;
  logic             w_timeout;
  logic             w_timeout_hit;
  logic             w_instr_end;
  logic             w_timer_clr;
  logic             w_timer_en;

  // Control word for a state; the registered copy always matches r_state.
  function automatic ctrl_out_t decode_state(input state_e s);
    ctrl_out_t o;
    o = '0;
    case (s)
      ST_FETCH: begin
        o.mem_read  = 1'b1;
        o.fetch_ld  = 1'b1;
        o.alu_src_b = ALUB_FOUR;
        o.alu_op    = ALUOP_ADD;
      end
      ST_DECODE: begin
        o.alu_src_b = ALUB_IMM_SH;
        o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = ALUB_IMM;
        o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        o.mem_read = 1'b1;
        o.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        o.mem_write = 1'b1;
        o.iord      = 1'b1;
      end
      ST_EXEC_R: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = ALUB_REG;
        o.alu_op    = ALUOP_FUNCT;
      end
      ST_EXEC_I: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = ALUB_IMM;
        o.alu_op    = ALUOP_FUNCT;
      end
      ST_ALU_WB: begin
        o.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        o.alu_src_a     = 1'b1;
        o.alu_src_b     = ALUB_REG;
        o.alu_op        = ALUOP_SUB;
        o.pc_write_cond = 1'b1;
        o.pc_src        = 1'b1;
      end
      ST_TRAP: begin
        o.trap = 1'b1;
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

  assign w_in_wait     = is_wait_state(r_state);
  assign w_timeout_hit = w_in_wait && w_timeout && !bus.mem_ready;
  assign w_instr_end   = (r_state == ST_MEM_WB) || (r_state == ST_ALU_WB) ||
                         (r_state == ST_BRANCH) ||
                         ((r_state == ST_MEM_WR) && bus.mem_ready);
  assign w_timer_clr   = (w_state_nxt != r_state);
  assign w_timer_en    = w_in_wait && !bus.mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_timer_clr),
    .i_enable  (w_timer_en),
    .o_timeout (w_timeout)
  );

  // Next-state and trap-cause selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_trap_cause;
    case (r_state)
      ST_IDLE: begin
        if (bus.run) w_state_nxt = ST_FETCH;
        else         w_state_nxt = ST_IDLE;
      end
      ST_FETCH: begin
        if (bus.mem_ready) begin
          w_state_nxt = ST_DECODE;
        end else if (w_timeout_hit) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = CAUSE_TIMEOUT;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_state_nxt = ST_MEM_ADDR;
          OP_RTYPE:          w_state_nxt = ST_EXEC_R;
          OP_ITYPE:          w_state_nxt = ST_EXEC_I;
          OP_BRANCH:         w_state_nxt = ST_BRANCH;
          default: begin
            w_state_nxt = ST_TRAP;
            w_cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        if (bus.opcode == OP_LOAD) w_state_nxt = ST_MEM_RD;
        else                       w_state_nxt = ST_MEM_WR;
      end
      ST_MEM_RD: begin
        if (bus.mem_ready) begin
          w_state_nxt = ST_MEM_WB;
        end else if (w_timeout_hit) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = CAUSE_TIMEOUT;
        end else begin
          w_state_nxt = ST_MEM_RD;
        end
      end
      ST_MEM_WR: begin
        if (bus.mem_ready) begin
          w_state_nxt = bus.run ? ST_FETCH : ST_IDLE;
        end else if (w_timeout_hit) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = CAUSE_TIMEOUT;
        end else begin
          w_state_nxt = ST_MEM_WR;
        end
      end
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH: begin
        w_state_nxt = bus.run ? ST_FETCH : ST_IDLE;
      end
      ST_EXEC_R, ST_EXEC_I: begin
        w_state_nxt = ST_ALU_WB;
      end
      ST_TRAP: begin
        w_state_nxt = ST_TRAP;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, registered control word, trap cause and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_out        <= '0;
      r_trap_cause <= CAUSE_NONE;
      r_retired    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_out        <= decode_state(w_state_nxt);
      r_trap_cause <= w_cause_nxt;
      if (w_instr_end) r_retired <= r_retired + RET_W'(1);
      else             r_retired <= r_retired;
    end
  end

  // Strobes drop in the cycle a wait times out; fetch loads need mem_ready.
  assign bus.mem_read      = r_out.mem_read & ~w_timeout_hit;
  assign bus.mem_write     = r_out.mem_write & ~w_timeout_hit;
  assign bus.iord          = r_out.iord;
  assign bus.ir_write      = r_out.fetch_ld & bus.mem_ready;
  assign bus.pc_write      = r_out.fetch_ld & bus.mem_ready;
  assign bus.pc_write_cond = r_out.pc_write_cond;
  assign bus.pc_src        = r_out.pc_src;
  assign bus.alu_src_a     = r_out.alu_src_a;
  assign bus.alu_src_b     = r_out.alu_src_b;
  assign bus.alu_op        = r_out.alu_op;
  assign bus.reg_write     = r_out.reg_write;
  assign bus.mem_to_reg    = r_out.mem_to_reg;
  assign bus.trap          = r_out.trap;
  assign bus.trap_cause    = r_trap_cause;
  assign bus.retired       = r_retired;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: builds expected per-cycle control traces from
// instruction-level rules, then replays them against the controller.
module tb_mc_control_fsm;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.RET_W(32)) u_if ();

  mc_control_fsm #(.MEM_TIMEOUT(T), .RET_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.master)
  );

  typedef struct {
    logic        rdy;
    logic        run;
    logic        zero;
    logic [6:0]  op;
    logic [16:0] vec;
    logic [31:0] ret;
  } step_t;

  step_t       q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int unsigned mdl_ret = 0;

  logic [16:0] V_ZERO, V_FETCH, V_FETCH_DONE, V_FETCH_TO, V_DECODE, V_MADDR;
  logic [16:0] V_MEMRD, V_MEMWB, V_MEMWR, V_EXR, V_EXI, V_ALUWB, V_BR;
  logic [16:0] V_TRAP_ILL, V_TRAP_TO;

  function automatic logic [16:0] mk(input logic mr, input logic mw, input logic iord,
                                     input logic irw, input logic pcw, input logic pcwc,
                                     input logic pcsrc, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic rw, input logic m2r,
                                     input logic tr, input logic [1:0] tc);
    return {mr, mw, iord, irw, pcw, pcwc, pcsrc, asa, asb, aop, rw, m2r, tr, tc};
  endfunction

  function automatic logic [16:0] obs();
    return {u_if.mem_read, u_if.mem_write, u_if.iord, u_if.ir_write, u_if.pc_write,
            u_if.pc_write_cond, u_if.pc_src, u_if.alu_src_a, u_if.alu_src_b, u_if.alu_op,
            u_if.reg_write, u_if.mem_to_reg, u_if.trap, u_if.trap_cause};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk_vec(input string tag, input logic [16:0] exp);
    logic [16:0] o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, exp);
    end
  endtask

  task automatic chk_ret(input string tag, input logic [31:0] exp);
    checks++;
    assert (u_if.retired === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, u_if.retired, exp);
    end
  endtask

  task automatic push(input logic rdy, input logic rn, input logic [6:0] op,
                      input logic [16:0] v);
    step_t s;
    s.rdy  = rdy;
    s.run  = rn;
    s.zero = rb();
    s.op   = op;
    s.vec  = v;
    s.ret  = mdl_ret;
    q.push_back(s);
  endtask

  // A memory handshake that completes on its k-th cycle.
  task automatic wait_phase(input int k, input logic [6:0] op, input logic [16:0] vbusy,
                            input logic [16:0] vdone, input logic last, input logic run_last);
    for (int i = 1; i < k; i++) push(1'b0, rb(), op, vbusy);
    push(1'b1, last ? run_last : rb(), op, vdone);
  endtask

  // kind: 0 load, 1 store, 2 R-type, 3 I-type, 4 branch; latency 0 = random.
  task automatic add_instr(input int kind, input int kf_in, input int km_in, input logic run_end);
    logic [6:0] op;
    int kf, km;
    kf = (kf_in == 0) ? int'($urandom_range(1, T + 1)) : kf_in;
    km = (km_in == 0) ? int'($urandom_range(1, T + 1)) : km_in;
    case (kind)
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      3: op = 7'b0010011;
      default: op = 7'b1100011;
    endcase
    wait_phase(kf, op, V_FETCH, V_FETCH_DONE, 1'b0, 1'b0);
    push(rb(), rb(), op, V_DECODE);
    case (kind)
      0: begin
        push(rb(), rb(), op, V_MADDR);
        wait_phase(km, op, V_MEMRD, V_MEMRD, 1'b0, 1'b0);
        push(rb(), run_end, op, V_MEMWB);
      end
      1: begin
        push(rb(), rb(), op, V_MADDR);
        wait_phase(km, op, V_MEMWR, V_MEMWR, 1'b1, run_end);
      end
      2: begin
        push(rb(), rb(), op, V_EXR);
        push(rb(), run_end, op, V_ALUWB);
      end
      3: begin
        push(rb(), rb(), op, V_EXI);
        push(rb(), run_end, op, V_ALUWB);
      end
      default: push(rb(), run_end, op, V_BR);
    endcase
    mdl_ret++;
  endtask

  task automatic run_q(input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      u_if.mem_ready = s.rdy;
      u_if.run       = s.run;
      u_if.zero      = s.zero;
      u_if.opcode    = s.op;
      #1;
      cyc++;
      chk_vec(tag, s.vec);
      chk_ret({tag, "_ret"}, s.ret);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    u_if.run = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_vec("reset_out", V_ZERO);
    chk_ret("reset_ret", 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    mdl_ret = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    V_ZERO       = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,2'b00);
    V_FETCH      = mk(1,0,0,0,0,0,0,0,2'b01,2'b00,0,0,0,2'b00);
    V_FETCH_DONE = mk(1,0,0,1,1,0,0,0,2'b01,2'b00,0,0,0,2'b00);
    V_FETCH_TO   = mk(0,0,0,0,0,0,0,0,2'b01,2'b00,0,0,0,2'b00);
    V_DECODE     = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,0,0,0,2'b00);
    V_MADDR      = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,0,2'b00);
    V_MEMRD      = mk(1,0,1,0,0,0,0,0,2'b00,2'b00,0,0,0,2'b00);
    V_MEMWB      = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,1,1,0,2'b00);
    V_MEMWR      = mk(0,1,1,0,0,0,0,0,2'b00,2'b00,0,0,0,2'b00);
    V_EXR        = mk(0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,0,2'b00);
    V_EXI        = mk(0,0,0,0,0,0,0,1,2'b10,2'b10,0,0,0,2'b00);
    V_ALUWB      = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,1,0,0,2'b00);
    V_BR         = mk(0,0,0,0,0,1,1,1,2'b00,2'b01,0,0,0,2'b00);
    V_TRAP_ILL   = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,2'b01);
    V_TRAP_TO    = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,2'b10);

    rst_n          = 1'b0;
    u_if.run       = 1'b0;
    u_if.opcode    = 7'd0;
    u_if.zero      = 1'b0;
    u_if.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_vec("por_out", V_ZERO);
    chk_ret("por_ret", 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with run low, then start.
    for (int i = 0; i < 3; i++) push(rb(), 1'b0, 7'($urandom), V_ZERO);
    push(rb(), 1'b1, 7'($urandom), V_ZERO);
    // Directed first instructions, then a random program ending with run low.
    add_instr(2, 1, 1, 1'b1);
    add_instr(0, 1, 3, 1'b1);
    add_instr(1, T + 1, T + 1, 1'b1);
    add_instr(4, 0, 0, 1'b1);
    add_instr(3, 0, 0, 1'b1);
    add_instr(0, T + 1, T + 1, 1'b1);
    for (int i = 0; i < 20; i++) add_instr(int'($urandom_range(0, 4)), 0, 0, 1'b1);
    add_instr(4, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) push(rb(), 1'b0, 7'($urandom), V_ZERO);
    run_q("prog");

    // Illegal opcode traps with cause 01 and ignores run.
    push(rb(), 1'b1, 7'h7f, V_ZERO);
    wait_phase(2, 7'h7f, V_FETCH, V_FETCH_DONE, 1'b0, 1'b0);
    push(rb(), rb(), 7'h7f, V_DECODE);
    for (int i = 0; i < 4; i++) push(rb(), 1'b1, 7'($urandom), V_TRAP_ILL);
    run_q("illegal");
    do_reset();

    // Reset asserted during MEM_WB discards the instruction and the count.
    push(rb(), 1'b1, 7'($urandom), V_ZERO);
    add_instr(2, 0, 0, 1'b1);
    add_instr(1, 0, 0, 1'b1);
    wait_phase(1, 7'b0000011, V_FETCH, V_FETCH_DONE, 1'b0, 1'b0);
    push(rb(), 1'b1, 7'b0000011, V_DECODE);
    push(rb(), 1'b1, 7'b0000011, V_MADDR);
    wait_phase(2, 7'b0000011, V_MEMRD, V_MEMRD, 1'b0, 1'b0);
    push(rb(), 1'b1, 7'b0000011, V_MEMWB);
    run_q("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("async_rst_out", V_ZERO);
    chk_ret("async_rst_ret", 32'd0);
    @(negedge clk);
    #1;
    chk_vec("held_rst_out", V_ZERO);
    u_if.run = 1'b0;
    rst_n    = 1'b1;
    mdl_ret  = 0;
    for (int i = 0; i < 2; i++) push(rb(), 1'b0, 7'($urandom), V_ZERO);
    run_q("post_rst");

    // Fetch timeout: ready low through T counted cycles plus the limit cycle.
    push(rb(), 1'b1, 7'($urandom), V_ZERO);
    for (int i = 0; i < T; i++) push(1'b0, rb(), 7'b0110011, V_FETCH);
    push(1'b0, rb(), 7'b0110011, V_FETCH_TO);
    for (int i = 0; i < 4; i++) push(rb(), 1'b1, 7'($urandom), V_TRAP_TO);
    run_q("timeout");
    do_reset();
    push(rb(), 1'b0, 7'($urandom), V_ZERO);
    run_q("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
